// File: rtl/prog_loader_pkg.sv
// Shared types for the program-RAM arbiter: FSM state encoding and drain length.
// Optional checksum logic in prog_loader_arb is enabled by PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_LOAD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Cycles spent in DRAIN so a fetch issued in the last IDLE cycle can return.
    localparam int DRAIN_CYCLES = 1;

endpackage

// File: rtl/prog_loader_arb_if.sv
// Loader byte stream and CPU fetch port of the program-RAM arbiter.
// master = loader/CPU side, slave = prog_loader_arb.
interface prog_loader_arb_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);

    // Handshake: a byte moves on a rising clk edge where ld_valid && ld_ready are
    // both high; ld_data/ld_last are sampled only on that edge. cpu_req is a plain
    // request, cpu_valid answers it one cycle later, and cpu_hold=1 means the
    // request is dropped.
    logic                  ld_valid;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_last;
    logic                  ld_ready;

    logic                  cpu_req;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_data;
    logic                  cpu_valid;
    logic                  cpu_hold;

    modport master (
        output ld_valid, ld_data, ld_last, cpu_req, cpu_addr,
        input  ld_ready, cpu_data, cpu_valid, cpu_hold
    );

    modport slave (
        input  ld_valid, ld_data, ld_last, cpu_req, cpu_addr,
        output ld_ready, cpu_data, cpu_valid, cpu_hold
    );

endinterface

// File: rtl/prog_loader_arb.sv
// Shares the single-port program RAM between CPU fetch and a byte-stream loader.
// Define PROG_LOADER_CHECKSUM_EN to compute a running byte sum on ld_sum.
module prog_loader_arb
    import prog_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    prog_loader_arb_if.slave      bus,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [ADDR_WIDTH:0]   ld_count,
    output logic                  ld_done,
    output logic                  ld_ovf,
    output logic [DATA_WIDTH-1:0] ld_sum,
    output state_t                dbg_state
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0]    DRAIN_END  = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST   = '1;
    localparam logic [ADDR_WIDTH:0]   COUNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  ovf_q;
    logic                  cpu_valid_q;
    logic [DRAIN_W-1:0]    drain_cnt;

    logic                  load_ok;
    logic                  xfer;
    logic                  final_xfer;
    logic                  ld_ready_c;
    logic                  cpu_hold_c;

    assign load_ok    = (state == S_IDLE) && load_start;
    assign xfer       = (state == S_LOAD) && bus.ld_valid;
    // The top address ends the load even without ld_last, so ptr never wraps to 0.
    assign final_xfer = xfer && (bus.ld_last || (ptr == PTR_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mem_addr   = ptr;
        mem_din    = '0;
        mem_we     = 1'b0;
        ld_ready_c = 1'b0;
        cpu_hold_c = 1'b1;
        ld_done    = 1'b0;
        case (state)
            S_IDLE: begin
                mem_addr   = bus.cpu_addr;
                cpu_hold_c = 1'b0;
                if (load_start) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_END) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                ld_ready_c = 1'b1;
                if (bus.ld_valid) begin
                    mem_we  = 1'b1;
                    mem_din = bus.ld_data;
                end
                if (final_xfer) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                ld_done   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            cpu_valid_q <= 1'b0;
            drain_cnt   <= '0;
        end else begin
            // Only IDLE grants fetches; a request in the load_start cycle still returns.
            cpu_valid_q <= (state == S_IDLE) && bus.cpu_req;
            if (load_ok) begin
                ptr       <= '0;
                count_q   <= '0;
                ovf_q     <= 1'b0;
                drain_cnt <= '0;
            end else begin
                if (state == S_DRAIN) begin
                    drain_cnt <= drain_cnt + 1'b1;
                end
                if (xfer) begin
                    if (ptr != PTR_LAST) begin
                        ptr <= ptr + 1'b1;
                    end
                    if (count_q != COUNT_FULL) begin
                        count_q <= count_q + 1'b1;
                    end
                    if (!bus.ld_last && (ptr == PTR_LAST)) begin
                        ovf_q <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (load_ok) begin
            sum_q <= '0;
        end else if (xfer) begin
            sum_q <= sum_q + bus.ld_data;
        end
    end

    assign ld_sum = sum_q;
`else
    assign ld_sum = '0;
`endif

    assign bus.ld_ready  = ld_ready_c;
    assign bus.cpu_hold  = cpu_hold_c;
    assign bus.cpu_valid = cpu_valid_q;
    assign bus.cpu_data  = cpu_valid_q ? mem_dout : '0;
    assign ld_count      = count_q;
    assign ld_ovf        = ovf_q;
    assign dbg_state     = state;

    a_we_only_in_load : assert property (
        @(posedge clk) disable iff (!rst_n) mem_we |-> (state == S_LOAD));
    a_no_fetch_in_load : assert property (
        @(posedge clk) disable iff (!rst_n) (state == S_LOAD) |-> !cpu_valid_q);
    a_drain_to_load : assert property (
        @(posedge clk) disable iff (!rst_n) (state == S_DRAIN) |=> (state == S_LOAD));

endmodule

// File: tb/tb_prog_loader_arb.sv
// Self-checking bench for prog_loader_arb (ADDR_WIDTH=4) with a behavioural RAM.
// Expected ld_sum follows PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader_arb;
  import prog_loader_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          load_start = 1'b0;
  logic          preload = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic [DW-1:0] mem_dout;
  logic [AW:0]   ld_count;
  logic          ld_done;
  logic          ld_ovf;
  logic [DW-1:0] ld_sum;
  state_t        dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] byte_q [$];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } fetch_vec_t;
  fetch_vec_t vecs [5];

  prog_loader_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  prog_loader_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .bus        (bus),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_we     (mem_we),
    .mem_dout   (mem_dout),
    .ld_count   (ld_count),
    .ld_done    (ld_done),
    .ld_ovf     (ld_ovf),
    .ld_sum     (ld_sum),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 5) ? 8'h11 : 8'(8'h10 + i);
  endfunction

  function automatic logic [DW-1:0] exp_sum_of(input logic [DW-1:0] s);
`ifdef PROG_LOADER_CHECKSUM_EN
    return s;
`else
    return (s & 8'h00);
`endif
  endfunction

  // Program RAM: write-enable, registered read, old data on read-during-write.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_val(i);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_din;
    end
    mem_dout <= ram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] e);
    bus.cpu_req = 1'b1;
    bus.cpu_addr = a;
    #1;
    check("fetch_mem_addr", mem_addr, a);
    check("fetch_hold", bus.cpu_hold, 0);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    #1;
    check("fetch_valid", bus.cpu_valid, 1);
    check("fetch_data", bus.cpu_data, e);
    @(negedge clk);
    #1;
    check("fetch_valid_drop", bus.cpu_valid, 0);
  endtask

  task automatic readback_all();
    for (int a = 0; a < DEPTH; a++) fetch(AW'(a), exp_mem[a]);
  endtask

  // Load byte_q[0..n-1]; gap1 idle cycles before byte 1, random gaps elsewhere.
  task automatic run_load(input int n, input bit with_last, input int gap1, input int max_gap,
                          input bit with_fetch, input logic [AW-1:0] faddr);
    logic [DW-1:0] sum_m;
    int gap;
    sum_m = '0;
    bus.cpu_req = with_fetch;
    bus.cpu_addr = faddr;
    load_start = 1'b1;
    #1;
    check("start_hold", bus.cpu_hold, 0);
    @(negedge clk);
    load_start = 1'b0;
    bus.cpu_req = 1'($urandom_range(0, 1));
    #1;
    check("drain_state", dbg_state, S_DRAIN);
    check("drain_hold", bus.cpu_hold, 1);
    check("drain_ready", bus.ld_ready, 0);
    check("drain_count", ld_count, 0);
    check("drain_ovf", ld_ovf, 0);
    check("drain_sum", ld_sum, 0);
    check("drain_cpu_valid", bus.cpu_valid, with_fetch);
    if (with_fetch) check("drain_cpu_data", bus.cpu_data, exp_mem[faddr]);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      gap = (i == 1) ? gap1 : $urandom_range(0, max_gap);
      for (int g = 0; g < gap; g++) begin
        bus.ld_valid = 1'b0;
        bus.cpu_req = 1'($urandom_range(0, 1));
        load_start = 1'($urandom_range(0, 1));
        #1;
        check("gap_we", mem_we, 0);
        check("gap_ready", bus.ld_ready, 1);
        check("gap_cpu_valid", bus.cpu_valid, 0);
        @(negedge clk);
      end
      bus.ld_valid = 1'b1;
      bus.ld_data = byte_q[i];
      bus.ld_last = with_last && (i == n - 1);
      load_start = 1'b0;
      #1;
      check("xfer_we", mem_we, 1);
      check("xfer_addr", mem_addr, i);
      check("xfer_din", mem_din, byte_q[i]);
      check("xfer_hold", bus.cpu_hold, 1);
      check("xfer_cpu_valid", bus.cpu_valid, 0);
      exp_mem[i] = byte_q[i];
      sum_m = sum_m + byte_q[i];
      @(negedge clk);
    end
    bus.ld_valid = 1'b0;
    bus.ld_last = 1'b0;
    bus.cpu_req = 1'b0;
    load_start = 1'b0;
    #1;
    check("done_pulse", ld_done, 1);
    check("done_ready", bus.ld_ready, 0);
    check("done_hold", bus.cpu_hold, 1);
    check("done_we", mem_we, 0);
    check("done_count", ld_count, n);
    check("done_ovf", ld_ovf, !with_last);
    check("done_sum", ld_sum, exp_sum_of(sum_m));
    @(negedge clk);
    #1;
    check("after_done_pulse", ld_done, 0);
    check("after_done_hold", bus.cpu_hold, 0);
    check("after_done_count", ld_count, n);
    check("after_done_state", dbg_state, S_IDLE);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit wl;
    bus.ld_valid = 1'b0;
    bus.ld_data = '0;
    bus.ld_last = 1'b0;
    bus.cpu_req = 1'b0;
    bus.cpu_addr = '0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = init_val(i);
    vecs[0] = '{addr: 4'd5,  data: 8'h11};
    vecs[1] = '{addr: 4'd0,  data: 8'h10};
    vecs[2] = '{addr: 4'd15, data: 8'h1F};
    vecs[3] = '{addr: 4'd3,  data: 8'h13};
    vecs[4] = '{addr: 4'd9,  data: 8'h19};

    #1 rst_n = 1'b0;
    preload = 1'b1;
    #2;
    check("rst_state", dbg_state, S_IDLE);
    check("rst_hold", bus.cpu_hold, 0);
    check("rst_valid", bus.cpu_valid, 0);
    check("rst_data", bus.cpu_data, 0);
    check("rst_ready", bus.ld_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_din", mem_din, 0);
    check("rst_count", ld_count, 0);
    check("rst_done", ld_done, 0);
    check("rst_ovf", ld_ovf, 0);
    check("rst_sum", ld_sum, 0);
    @(negedge clk);
    @(negedge clk);
    preload = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Table of IDLE fetches against the preloaded image.
    for (int v = 0; v < 5; v++) fetch(vecs[v].addr, vecs[v].data);

    // Load with a same-cycle fetch of addr 3, then A0/A1/A2 with a 2-cycle gap.
    byte_q.delete();
    byte_q.push_back(8'hA0);
    byte_q.push_back(8'hA1);
    byte_q.push_back(8'hA2);
    run_load(3, 1'b1, 2, 0, 1'b1, 4'd3);
    check("seq_count_3", ld_count, 3);
    fetch(4'd2, 8'hA2);

    // Fill every address without ld_last: overflow, no wrap into addr 0.
    byte_q.delete();
    byte_q.push_back(8'h5C);
    for (int i = 1; i < DEPTH; i++) byte_q.push_back(8'($urandom_range(0, 255)));
    run_load(DEPTH, 1'b0, 1, 1, 1'b0, 4'd0);
    check("ovf_sticky", ld_ovf, 1);
    check("ovf_count", ld_count, 16);
    fetch(4'd0, 8'h5C);

    // Checksum wrap; the drain checks inside also confirm ld_ovf cleared.
    byte_q.delete();
    byte_q.push_back(8'hFF);
    byte_q.push_back(8'h02);
    run_load(2, 1'b1, 0, 0, 1'b0, 4'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
    check("cksum_ff02", ld_sum, 8'h01);
`else
    check("cksum_ff02", ld_sum, 8'h00);
`endif
    check("ovf_cleared", ld_ovf, 0);

    // Randomized loads, each verified by a full readback against the model.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, DEPTH);
      wl = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      byte_q.delete();
      for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom_range(0, 255)));
      run_load(n, wl, $urandom_range(0, 3), 3, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)));
      readback_all();
    end

    // Asynchronous reset after two bytes of a load.
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data = 8'(8'hC0 + i);
      bus.ld_last = 1'b0;
      exp_mem[i] = 8'(8'hC0 + i);
      @(negedge clk);
    end
    bus.ld_valid = 1'b0;
    #1;
    check("mid_load_count", ld_count, 2);
    check("mid_load_state", dbg_state, S_LOAD);
    rst_n = 1'b0;
    #1;
    check("arst_state", dbg_state, S_IDLE);
    check("arst_hold", bus.cpu_hold, 0);
    check("arst_ready", bus.ld_ready, 0);
    check("arst_count", ld_count, 0);
    check("arst_we", mem_we, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_release_hold", bus.cpu_hold, 0);
    @(negedge clk);
    fetch(4'd1, exp_mem[1]);
    fetch(4'd7, exp_mem[7]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prog_loader_arb.md
Name: prog_loader_arb

Overview:
- Owns the single-port program RAM (registered read, write-enable, one clock) and shares it between CPU instruction fetch and a byte-stream program loader (UART/debug side).
- In normal run the CPU owns the RAM; on a load request the block stalls the CPU, drains any in-flight fetch, then writes incoming bytes to sequential addresses from 0 and hands the RAM back.
- Sits between the CPU control unit and the program RAM instance.

Parameters:
- ADDR_WIDTH, 8, program RAM address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, instruction/byte width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  one-cycle pulse requesting a program load; ignored unless state is IDLE.
- ld_valid  in  1  loader byte valid.
- ld_data  in  DATA_WIDTH  loader byte.
- ld_last  in  1  qualifies the final byte of the image (sampled with ld_valid).
- ld_ready  out  1  loader may present a byte; a byte transfers when ld_valid and ld_ready are both high.
- cpu_req  in  1  CPU fetch request.
- cpu_addr  in  ADDR_WIDTH  CPU fetch address (PC).
- cpu_data  out  DATA_WIDTH  fetched instruction byte.
- cpu_valid  out  1  cpu_data valid, exactly one cycle after a granted cpu_req.
- cpu_hold  out  1  CPU must stall; asserted whenever the CPU does not own the RAM.
- mem_addr  out  ADDR_WIDTH  to RAM Addr.
- mem_din  out  DATA_WIDTH  to RAM din.
- mem_we  out  1  to RAM write_en.
- mem_dout  in  DATA_WIDTH  from RAM Data (registered; valid one cycle after mem_addr).
- ld_count  out  ADDR_WIDTH+1  bytes written in the current/last load.
- ld_done  out  1  one-cycle pulse at load completion.
- ld_ovf  out  1  sticky: the last load filled the RAM without ld_last; cleared by the next load_start.
- ld_sum  out  DATA_WIDTH  checksum (see Optional Feature).

Behaviour:
- Reset (rst_n low, async): state IDLE; cpu_hold=0, cpu_valid=0, cpu_data=0, ld_ready=0, mem_we=0, mem_addr=0, mem_din=0, ld_count=0, ld_done=0, ld_ovf=0, ld_sum=0, write pointer=0.
- IDLE: mem_addr=cpu_addr, mem_we=0, ld_ready=0. cpu_valid registers cpu_req, so it is high the cycle after a request. cpu_data=mem_dout. load_start -> DRAIN, with cpu_hold=1 from the next cycle.
- A load_start arriving in the same cycle as cpu_req: the fetch is still granted and its cpu_valid still fires in DRAIN.
- DRAIN (exactly 1 cycle): lets a fetch issued in the IDLE cycle complete. cpu_hold=1. ld_count, ld_ovf, ld_sum and the pointer clear. -> LOAD.
- LOAD: cpu_hold=1, ld_ready=1, cpu_valid=0. Each transfer drives mem_addr=ptr, mem_din=ld_data, mem_we=1 combinationally in that cycle, then increments ptr and ld_count. mem_we=0 on cycles without a transfer. The loader may stall arbitrarily.
- LOAD exit: a transfer with ld_last=1 -> DONE. A transfer at ptr=2**ADDR_WIDTH-1 with ld_last=0 -> DONE and sets ld_ovf. The pointer never wraps into address 0.
- DONE (1 cycle): ld_done=1, ld_ready=0, cpu_hold=1. -> IDLE; cpu_hold drops the following cycle. The CPU must restart fetch itself; PC reset is the CPU's responsibility.
- load_start outside IDLE is ignored.
- cpu_req while cpu_hold=1 is ignored; no cpu_valid is produced.
- Async reset mid-LOAD: immediate return to IDLE, cpu_hold=0. RAM contents are partial and undefined.
- ld_count saturates at 2**ADDR_WIDTH and holds its value after DONE until the next load.

Optional Feature:
- Macro PROG_LOADER_CHECKSUM_EN.
- Defined: ld_sum is an 8-bit-wide (DATA_WIDTH) modulo-2**DATA_WIDTH sum of all bytes transferred in the current load. It clears in DRAIN and holds its value after DONE.
- Undefined: the ld_sum port still exists, tied to 0, and no adder is synthesized.

Decomposition:
- Package prog_loader_pkg holds the state encoding (IDLE, DRAIN, LOAD, DONE as a 2-bit enum) and the DRAIN length constant (1).
- No sub-module: the FSM, pointer and mux are one block. The RAM stays a separate instance wired to the mem_* ports.

Test Plan:
- CPU fetch in IDLE, RAM preloaded 0x11 at addr 5: cpu_req=1, cpu_addr=5 -> cpu_valid=1 next cycle with cpu_data=0x11, cpu_hold=0.
- load_start with a same-cycle fetch of addr 3 -> cpu_valid fires in the DRAIN cycle with the old data. cpu_hold=1 from the DRAIN cycle through DONE.
- Load bytes 0xA0, 0xA1, 0xA2 (last on 3rd), with a 2-cycle ld_valid gap after the first -> mem_we pulses at addr 0, 1, 2 only. ld_count=3, ld_done one pulse, then a CPU read of addr 2 returns 0xA2.
- ADDR_WIDTH=4, 16 bytes with no ld_last -> DONE after the 16th byte, ld_ovf=1, ld_count=16, addr 0 not overwritten. The next load_start clears ld_ovf.
- rst_n low for 1 cycle mid-LOAD after 2 bytes -> IDLE immediately, cpu_hold=0, ld_ready=0, ld_count=0.
- With PROG_LOADER_CHECKSUM_EN, load 0xFF, 0x02 -> ld_sum=0x01. Without the macro, ld_sum=0x00.
